// File: rtl/rr_pkt_arb.sv
// rr_pkt_arb: round-robin packet arbiter merging N_SRC AXI-Stream sources into one stream through a 2-entry FIFO.
// Optional feature: define RR_PKT_ARB_PKTCNT_EN to add the 16-bit pkt_cnt output.

module rr_pkt_arb #(
   parameter int DATA_WIDTH = 64,
   parameter int N_SRC      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_SRC*DATA_WIDTH-1:0] src_TDATA,
   input  logic [N_SRC-1:0]            src_TVALID,
   output logic [N_SRC-1:0]            src_TREADY,
   input  logic [N_SRC-1:0]            src_TLAST,
   output logic [DATA_WIDTH-1:0]       res_TDATA,
   output logic                        res_TVALID,
   input  logic                        res_TREADY,
   output logic                        res_TLAST,
   output logic [2:0]                  grant,
   output logic                        locked
`ifdef RR_PKT_ARB_PKTCNT_EN
   ,
   output logic [15:0]                 pkt_cnt
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } flit_t;

   state_t                state;
   logic [2:0]            ptr;
   logic [2:0]            next_sel;
   logic [2:0]            cand;

   // Sources padded to 8 so the 3-bit grant indexes them without width games.
   logic [7:0]            valid_pad;
   logic [7:0]            last_pad;
   logic [DATA_WIDTH-1:0] src_data [8];

   flit_t                 mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic                  full;
   logic                  push;
   logic                  pop;

   assign valid_pad = 8'(src_TVALID);
   assign last_pad  = 8'(src_TLAST);

   for (genvar i = 0; i < 8; i++) begin : g_src
      if (i < N_SRC) begin : g_used
         assign src_data[i] = src_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_unused
         assign src_data[i] = '0;
      end
   end

   // Scanning from the farthest offset down leaves the nearest valid source after ptr.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      next_sel = '0;
      cand     = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         cand = 3'((int'(ptr) + k) % N_SRC);
         if (valid_pad[cand]) next_sel = cand;
      end
   end

   assign full       = (count == 2'd2);
   assign res_TVALID = (count != 2'd0);
   assign push       = (state == LOCKED) && valid_pad[grant] && !full;
   assign pop        = res_TVALID && res_TREADY;
   assign res_TDATA  = res_TVALID ? mem[rd_ptr].data : '0;
   assign res_TLAST  = res_TVALID && mem[rd_ptr].last;

   always_comb begin
      src_TREADY = '0;
      for (int i = 0; i < N_SRC; i++) begin
         src_TREADY[i] = (state == LOCKED) && (grant == 3'(i)) && !full;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         state  <= IDLE;
         ptr    <= 3'(N_SRC - 1);
         grant  <= '0;
         locked <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|src_TVALID) begin
                  grant  <= next_sel;
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
            LOCKED: begin
               if (push && last_pad[grant]) begin
                  ptr    <= grant;
                  state  <= IDLE;
                  locked <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage is deliberately not reset; clearing count discards its contents and outputs are gated by it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{data: src_data[grant], last: last_pad[grant]};
   end

`ifdef RR_PKT_ARB_PKTCNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt <= '0;
      end else if (pop && res_TLAST) begin
         pkt_cnt <= pkt_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_pkt_arb.sv
// tb_rr_pkt_arb: directed scenarios plus randomized traffic against a queue-based reference model of rr_pkt_arb.
// With RR_PKT_ARB_PKTCNT_EN defined the model also tracks pkt_cnt.

module tb_rr_pkt_arb;

   localparam int DW = 16;
   localparam int NS = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } flit_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NS*DW-1:0] src_TDATA;
   logic [NS-1:0]    src_TVALID;
   logic [NS-1:0]    src_TREADY;
   logic [NS-1:0]    src_TLAST;
   logic [DW-1:0]    res_TDATA;
   logic             res_TVALID;
   logic             res_TREADY;
   logic             res_TLAST;
   logic [2:0]       grant;
   logic             locked;
`ifdef RR_PKT_ARB_PKTCNT_EN
   logic [15:0]      pkt_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state: a queue stands in for the output buffer.
   flit_t m_q[$];
   bit    m_locked;
   int    m_grant;
   int    m_ptr;
   int    m_pkt;

   // Values sampled at the negedge preceding the latest tick's clock edge.
   logic [NS-1:0] t_hs;
   logic [NS-1:0] t_rdy;
   logic          t_pop;
   logic          t_rvalid;
   logic [DW-1:0] t_data;
   logic          t_locked;
   logic [2:0]    t_grant;

   rr_pkt_arb #(.DATA_WIDTH(DW), .N_SRC(NS)) dut (
      .clk        (clk),
      .rst        (rst),
      .src_TDATA  (src_TDATA),
      .src_TVALID (src_TVALID),
      .src_TREADY (src_TREADY),
      .src_TLAST  (src_TLAST),
      .res_TDATA  (res_TDATA),
      .res_TVALID (res_TVALID),
      .res_TREADY (res_TREADY),
      .res_TLAST  (res_TLAST),
      .grant      (grant),
      .locked     (locked)
`ifdef RR_PKT_ARB_PKTCNT_EN
      ,
      .pkt_cnt    (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_locked = 1'b0;
      m_grant  = 0;
      m_ptr    = NS - 1;
      m_pkt    = 0;
   endtask

   // Per-cycle compare against the model, then advance the model with the inputs held over the next edge.
   initial begin
      bit            exp_valid;
      bit            do_push;
      bit            do_pop;
      logic [NS-1:0] exp_rdy;
      flit_t         f;
      int            c;
      m_reset();
      forever begin
         @(negedge clk);
         if (!rst) m_reset();
         exp_valid = (m_q.size() != 0);
         exp_rdy   = '0;
         if (m_locked && m_q.size() < 2) exp_rdy[m_grant] = 1'b1;
         check("res_TVALID", 64'(res_TVALID), 64'(exp_valid));
         check("res_TDATA", 64'(res_TDATA), exp_valid ? 64'(m_q[0].data) : 64'd0);
         check("res_TLAST", 64'(res_TLAST), exp_valid ? 64'(m_q[0].last) : 64'd0);
         check("src_TREADY", 64'(src_TREADY), 64'(exp_rdy));
         check("locked", 64'(locked), 64'(m_locked));
         if (m_locked) check("grant", 64'(grant), 64'(m_grant));
`ifdef RR_PKT_ARB_PKTCNT_EN
         check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
`endif
         if (rst) begin
            do_pop  = exp_valid && res_TREADY;
            do_push = m_locked && src_TVALID[m_grant] && (m_q.size() < 2);
            if (do_pop) begin
               f = m_q.pop_front();
               if (f.last) m_pkt = (m_pkt + 1) % 65536;
            end
            if (do_push) begin
               m_q.push_back('{data: src_TDATA[m_grant*DW +: DW], last: src_TLAST[m_grant]});
               if (src_TLAST[m_grant]) begin
                  m_locked = 1'b0;
                  m_ptr    = m_grant;
               end
            end else if (!m_locked && |src_TVALID) begin
               for (int k = 1; k <= NS; k++) begin
                  c = (m_ptr + k) % NS;
                  if (src_TVALID[c]) begin
                     m_grant  = c;
                     m_locked = 1'b1;
                     break;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      t_hs     = src_TVALID & src_TREADY;
      t_rdy    = src_TREADY;
      t_pop    = res_TVALID && res_TREADY;
      t_rvalid = res_TVALID;
      t_data   = res_TDATA;
      t_locked = locked;
      t_grant  = grant;
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
      src_TVALID[i]         = v;
      src_TDATA[i*DW +: DW] = d;
      src_TLAST[i]          = l;
   endtask

   // Ticks until a handshake occurs on any source in mask; a missing handshake counts as a failure.
   task automatic wait_hs(input logic [NS-1:0] mask);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         tick();
         ok = |(t_hs & mask);
      end
      check("hs_timeout", 64'(ok), 64'd1);
   endtask

   initial begin
      int         gl [5];
      logic [DW-1:0] pl [5];
      int         ng;
      int         np;
      int         pops_win;
      int         acc;
      int         rem [NS];
      int         cnt [NS];
      int         pk;

      rst        = 1'b0;
      src_TVALID = '0;
      src_TDATA  = '0;
      src_TLAST  = '0;
      res_TREADY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res_TVALID", 64'(res_TVALID), 64'd0);
      check("rst_res_TDATA", 64'(res_TDATA), 64'd0);
      check("rst_res_TLAST", 64'(res_TLAST), 64'd0);
      check("rst_src_TREADY", 64'(src_TREADY), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_locked", 64'(locked), 64'd0);
      rst = 1'b1;

      // All sources valid with single-flit packets: rotation 0,1,2,3,0 at one flit per two cycles.
      res_TREADY = 1'b1;
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, 16'(i << 8), 1'b1);
      ng = 0; np = 0; pops_win = 0;
      for (int n = 0; n < 14; n++) begin
         tick();
         if (t_locked && ng < 5) begin
            gl[ng] = int'(t_grant);
            ng++;
         end
         if (t_pop) begin
            if (np < 5) pl[np] = t_data;
            np++;
            if (n >= 2 && n <= 11) pops_win++;
         end
      end
      check("A_grant_count", 64'(ng), 64'd5);
      check("A_grant0", 64'(gl[0]), 64'd0);
      check("A_grant1", 64'(gl[1]), 64'd1);
      check("A_grant2", 64'(gl[2]), 64'd2);
      check("A_grant3", 64'(gl[3]), 64'd3);
      check("A_grant4", 64'(gl[4]), 64'd0);
      check("A_flits_per_10", 64'(pops_win), 64'd5);
      check("A_data1", 64'(pl[1]), 64'h100);
      check("A_data3", 64'(pl[3]), 64'h300);
      check("A_data4", 64'(pl[4]), 64'h000);
      wait_hs('1);
      src_TVALID = '0;
      repeat (3) tick();

      // Source 2 stalls mid-packet while source 0 waits: the lock must hold until source 2's TLAST.
      set_src(2, 1'b1, 16'h2000, 1'b0);
      wait_hs(4'b0100);
      set_src(0, 1'b1, 16'h0AAA, 1'b1);
      set_src(2, 1'b1, 16'h2001, 1'b0);
      wait_hs(4'b0100);
      src_TVALID[2] = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         check("B_grant_hold", 64'(t_grant), 64'd2);
         check("B_locked_hold", 64'(t_locked), 64'd1);
         check("B_src0_ready", 64'(t_rdy[0]), 64'd0);
      end
      set_src(2, 1'b1, 16'h2002, 1'b0);
      wait_hs(4'b0100);
      set_src(2, 1'b1, 16'h2003, 1'b1);
      wait_hs(4'b0100);
      src_TVALID[2] = 1'b0;
      wait_hs(4'b0001);
      check("B_next_grant", 64'(t_grant), 64'd0);
      src_TVALID[0] = 1'b0;
      repeat (3) tick();

      // Output stalled during a 5-flit packet: buffer takes two flits, then the rest drain in order.
      res_TREADY = 1'b0;
      acc = 0;
      set_src(1, 1'b1, 16'h1000, 1'b0);
      for (int n = 0; n < 10; n++) begin
         tick();
         if (t_hs[1]) acc++;
         if (t_rvalid) check("C_stall_data", 64'(t_data), 64'h1000);
         set_src(1, acc < 5, 16'(16'h1000 + acc), acc == 4);
      end
      check("C_accepted_while_stalled", 64'(acc), 64'd2);
      check("C_src1_ready_stalled", 64'(t_rdy[1]), 64'd0);
      res_TREADY = 1'b1;
      np = 0;
      for (int n = 0; n < 30 && np < 5; n++) begin
         tick();
         if (t_hs[1]) acc++;
         if (t_pop) begin
            check("C_drain_order", 64'(t_data), 64'(16'h1000 + np));
            np++;
         end
         set_src(1, acc < 5, 16'(16'h1000 + acc), acc == 4);
      end
      check("C_drain_count", 64'(np), 64'd5);
      src_TVALID = '0;
      repeat (3) tick();

      // Reset mid-packet with two flits buffered; output must clear immediately and source 0 win next.
      res_TREADY = 1'b0;
      acc = 0;
      set_src(3, 1'b1, 16'h3000, 1'b0);
      for (int n = 0; n < 20 && acc < 2; n++) begin
         tick();
         if (t_hs[3]) acc++;
         set_src(3, 1'b1, 16'(16'h3000 + acc), 1'b0);
      end
      check("D_buffered", 64'(acc), 64'd2);
      check("D_pre_rst_valid", 64'(res_TVALID), 64'd1);
      #1;
      rst = 1'b0;
      #1;
      check("D_rst_res_TVALID", 64'(res_TVALID), 64'd0);
      check("D_rst_src_TREADY", 64'(src_TREADY), 64'd0);
      check("D_rst_locked", 64'(locked), 64'd0);
      src_TVALID = '0;
      repeat (2) tick();
      rst        = 1'b1;
      res_TREADY = 1'b1;
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, 16'(16'h4000 + i), 1'b1);
      wait_hs('1);
      check("D_next_grant", 64'(t_grant), 64'd0);
      check("D_first_hs", 64'(t_hs), 64'b0001);
      src_TVALID = '0;
      repeat (3) tick();

      // Randomized traffic: packet lengths 1..5, bursty TVALID and res_TREADY.
      for (int i = 0; i < NS; i++) begin
         rem[i] = 0;
         cnt[i] = 0;
      end
      pk = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         for (int i = 0; i < NS; i++) begin
            if (t_hs[i]) begin
               rem[i]--;
               cnt[i]++;
               if (rem[i] == 0) pk++;
            end
            if (rem[i] == 0 && ($urandom % 4) == 0) rem[i] = int'($urandom_range(1, 5));
            set_src(i, (rem[i] > 0) && (($urandom % 10) < 7), {4'(i), 12'(cnt[i])}, rem[i] == 1);
         end
         res_TREADY = (($urandom % 10) < 7);
      end
      check("R_packets_moved", 64'(pk > 100), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rr_pkt_arb.md
RR_PKT_ARB -- requirements
Module: rr_pkt_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: TDATA width per stream.
REQ-002 SHALL have parameter N_SRC, default 4, legal 2..8: number of source streams.
REQ-003 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: src_TDATA  in  N_SRC*DATA_WIDTH  packed; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports: src_TVALID  in  N_SRC; src_TREADY  out  N_SRC; src_TLAST  in  N_SRC.
REQ-007 SHALL have ports: res_TDATA  out  DATA_WIDTH; res_TVALID  out  1; res_TREADY  in  1; res_TLAST  out  1.
REQ-008 SHALL have ports: grant  out  3  index of the locked source, valid only while locked.
REQ-009 SHALL have ports: locked  out  1  high while a packet is granted.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and LOCKED, as the sole arbitration control.
REQ-011 SHALL, in IDLE with any src_TVALID high, select the first valid source searching upward from (ptr+1) mod N_SRC, register it into grant, and enter LOCKED next cycle.
REQ-012 SHALL hold all src_TREADY low in IDLE; IDLE to first accepted flit costs exactly one bubble cycle.
REQ-013 SHALL, in LOCKED, drive src_TREADY[grant] = buffer not full and all other src_TREADY bits low.
REQ-014 SHALL count a flit transfer only when src_TVALID[grant] and src_TREADY[grant] are both high.
REQ-015 SHALL, on a transferred flit with src_TLAST[grant] high, load ptr <= grant and return to IDLE next cycle.
REQ-016 SHALL keep the lock when the granted source deasserts TVALID mid-packet; no re-arbitration before TLAST.
REQ-017 SHALL treat a single-flit packet (TLAST on first flit) as a complete packet per REQ-015.
REQ-018 SHALL ignore TLAST on non-granted sources.
REQ-019 SHALL pass flits through a 2-entry FIFO output buffer carrying {TDATA, TLAST}: res_TVALID = entries != 0; full = entries == 2.
REQ-020 SHALL present each accepted flit on res_* the cycle after acceptance (latency 1) when the buffer was empty.
REQ-021 SHALL sustain one flit per cycle within a packet while res_TREADY stays high.
REQ-022 SHALL allow simultaneous push and pop in one cycle at any occupancy of 1; entries unchanged.
REQ-023 SHALL hold res_TDATA/res_TLAST stable while res_TVALID is high and res_TREADY is low.
REQ-024 SHALL keep ptr width 3 bits with wrap from N_SRC-1 to 0; unused high grant bits read 0.

Reset
REQ-025 SHALL, with rst low, immediately force: FSM IDLE, ptr = N_SRC-1 (source 0 wins first), grant = 0, locked = 0, buffer empty.
REQ-026 SHALL drive during reset: res_TVALID = 0, res_TLAST = 0, res_TDATA = 0, all src_TREADY = 0.
REQ-027 SHALL discard buffered flits and any partial packet on reset mid-operation; no flit is emitted after rst rises until a new arbitration.
REQ-028 SHALL leave reset deassertion timing to the integrating clock domain; all internal state uses asynchronous clear only.

Configuration
REQ-029 SHALL, when macro RR_PKT_ARB_PKTCNT_EN is defined, add output pkt_cnt (16 bits), incrementing by 1 per res TLAST flit popped (res_TVALID, res_TREADY and res_TLAST high), wrapping 0xFFFF to 0, reset to 0.
REQ-030 SHALL, when RR_PKT_ARB_PKTCNT_EN is undefined, omit the pkt_cnt port and counter entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: rst low for 3 cycles, then src_TVALID=4'b1111, all single-flit packets, res_TREADY=1 -> grants in order 0,1,2,3,0, one flit per two cycles.
REQ-032 SHALL cover: src 2 sends 4-flit packet, TVALID dropped on flit 2 for 3 cycles while src 0 valid -> grant stays 2, src_TREADY[0]=0 until src 2 TLAST, then src 0.
REQ-033 SHALL cover: res_TREADY=0 during 5-flit packet -> exactly 2 flits accepted, src_TREADY[grant]=0, res_TDATA stable; release -> remaining 3 flits in order, no loss or duplication.
REQ-034 SHALL cover: rst pulsed low mid-packet with 2 flits buffered -> res_TVALID=0 in the same cycle, next grant goes to source 0.
REQ-035 SHALL cover: with RR_PKT_ARB_PKTCNT_EN, preload 65534 packets (or force) then send 3 packets -> pkt_cnt reads 0xFFFF, 0x0000, 0x0001.
